// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Optional packet lock is enabled with UART_ARB_PKT_LOCK_EN.
package uart_pkg;
  localparam int BYTE_W  = 8;
  localparam int GRANT_W = 3;

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    WAIT_DONE,
    GAP
  } arb_state_e;
endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request
// at or above the pointer, wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [GRANT_W-1:0] idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = GRANT_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter.
// Define UART_ARB_PKT_LOCK_EN to add req_last packet locking.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
`ifdef UART_ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_start_tx,
  output logic [BYTE_W-1:0]         uart_data,
  input  logic                      uart_busy,
  input  logic                      uart_tx_done,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      active,
  output logic                      wdog_err
);

  localparam logic [9:0] WDOG_LAST = 10'(WDOG_CYCLES - 1);
  localparam logic [9:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 10'(GAP_CYCLES - 1) : 10'd0;

  arb_state_e           state_q;
  logic [GRANT_W-1:0]   rr_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [BYTE_W-1:0]    data_q;
  logic                 start_q;
  logic                 active_q;
  logic                 wdog_q;
  logic [9:0]           cnt_q;

  logic [NUM_REQ-1:0]   pick_req;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [GRANT_W-1:0]   pick_ptr;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_any;
  logic                 win_last;
  logic [GRANT_W-1:0]   rr_nxt;
  logic                 busy_unused;

  // Transmitter busy is only observed by verification.
  assign busy_unused = uart_busy;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q;

  always_comb begin
    pick_req = req_valid;
    pick_ptr = rr_q;
    if (lock_q) begin
      pick_req = req_valid & (NUM_REQ'(1) << grant_q);
      pick_ptr = grant_q;
    end
  end

  assign win_last = req_last[pick_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (state_q == ARB && pick_any) begin
      lock_q <= !win_last;
    end
  end
`else
  assign pick_req = req_valid;
  assign pick_ptr = rr_q;
  assign win_last = 1'b1;
`endif

  uart_rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i (pick_req),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign rr_nxt = (pick_idx == GRANT_W'(NUM_REQ - 1))
                ? '0 : pick_idx + 1'b1;

  assign req_ready =
    (state_q == ARB && !reset) ? pick_gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      rr_q     <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      wdog_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ARB: begin
          if (pick_any) begin
            data_q   <= req_data[pick_idx*BYTE_W +: BYTE_W];
            grant_q  <= pick_idx;
            active_q <= 1'b1;
            start_q  <= 1'b1;
            state_q  <= ISSUE;
            if (win_last) rr_q <= rr_nxt;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (uart_tx_done) begin
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (cnt_q >= WDOG_LAST) begin
            wdog_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q >= GAP_LAST) begin
            active_q <= 1'b0;
            state_q  <= ARB;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign uart_start_tx = start_q;
  assign uart_data     = data_q;
  assign grant_id      = grant_q;
  assign active        = active_q;
  assign wdog_err      = wdog_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a queue-based
// arbitration model and a simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 2;
  localparam int WDOG = 1023;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           uart_start_tx;
  logic [7:0]     uart_data;
  logic           uart_busy = 1'b0;
  logic           uart_tx_done = 1'b0;
  logic [2:0]     grant_id;
  logic           active;
  logic           wdog_err;
`ifdef UART_ARB_PKT_LOCK_EN
  logic [N-1:0]   req_last = '1;
  bit             src_lq[N][$];
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
`ifdef UART_ARB_PKT_LOCK_EN
    .req_last(req_last),
`endif
    .req_ready(req_ready),
    .uart_start_tx(uart_start_tx), .uart_data(uart_data),
    .uart_busy(uart_busy), .uart_tx_done(uart_tx_done),
    .grant_id(grant_id), .active(active), .wdog_err(wdog_err)
  );

  typedef struct { int idx; logic [7:0] data; int cyc; } acc_t;
  typedef struct { int gid; logic [7:0] data; int cyc; } st_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wdog_rise = -1;
  bit tx_hang = 1'b0;

  logic [7:0] src_q[N][$];
  logic [7:0] m_q[N][$];
  int         rr_m = 0;
  int         exp_i[$];
  logic [7:0] exp_d[$];

  acc_t acc_log[$];
  st_t  st_log[$];
  int   done_log[$];
  int   fall_log[$];

  // Requester drivers: hold each byte until accepted.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          void'(src_q[i].pop_front());
`ifdef UART_ARB_PKT_LOCK_EN
          void'(src_lq[i].pop_front());
`endif
        end
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = src_q[i][0];
`ifdef UART_ARB_PKT_LOCK_EN
          req_last[i] = src_lq[i][0];
`endif
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter: busy after strobe, done after random delay.
  initial begin
    logic st, rs;
    int left;
    left = 0;
    forever begin
      @(negedge clk);
      st = uart_start_tx;
      rs = reset;
      @(posedge clk);
      #1;
      uart_tx_done = 1'b0;
      if (rs) begin
        left = 0;
        uart_busy = 1'b0;
      end else if (st) begin
        uart_busy = 1'b1;
        left = tx_hang ? -1 : int'($urandom_range(3, 8));
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          uart_tx_done = 1'b1;
          uart_busy = 1'b0;
        end
      end else if (left < 0 && !tx_hang) begin
        left = 0;
        uart_busy = 1'b0;
      end
    end
  end

  // Monitor: event log plus handshake and busy protocol checks.
  initial begin
    logic [N-1:0] vprev, aprev;
    logic act_prev, wd_prev;
    int bwait;
    vprev = '0; aprev = '0; act_prev = 0; wd_prev = 0; bwait = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          acc_log.push_back('{i, req_data[8*i +: 8], cyc});
        if (vprev[i] && !aprev[i] && !req_valid[i] && !reset) begin
          checks++;
          $display("FAIL handshake: req %0d valid dropped before ready", i);
        end
      end
      if (uart_start_tx)
        st_log.push_back('{int'(grant_id), uart_data, cyc});
      if (uart_tx_done) done_log.push_back(cyc);
      if (act_prev && !active) fall_log.push_back(cyc);
      if (wdog_err && !wd_prev) wdog_rise = cyc;
      if (uart_start_tx) bwait = 3;
      else if (bwait > 0) begin
        if (uart_busy || reset) bwait = 0;
        else begin
          bwait--;
          if (bwait == 0) begin
            checks++;
            $display("FAIL busy_after_start: busy=0 want 1 at cycle %0d", cyc);
          end
        end
      end
      act_prev = active;
      wd_prev  = wdog_err;
      vprev    = req_valid;
      aprev    = req_valid & req_ready;
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
    m_q[i].push_back(b);
`ifdef UART_ARB_PKT_LOCK_EN
    src_lq[i].push_back(1'b1);
`endif
  endtask

  // Reference: strict rotation over pending bytes, all present at once.
  task automatic model_run();
    bit found;
    int j;
    exp_i.delete();
    exp_d.delete();
    do begin
      found = 0;
      for (int k = 0; k < N && !found; k++) begin
        j = (rr_m + k) % N;
        if (m_q[j].size() > 0) begin
          exp_i.push_back(j);
          exp_d.push_back(m_q[j].pop_front());
          rr_m = (j + 1) % N;
          found = 1;
        end
      end
    end while (found);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    st_log.delete();
    done_log.delete();
    fall_log.delete();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    bit empty;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      empty = 1;
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0) empty = 0;
      if (empty && !active && req_valid == '0) ok = 1;
    end
    checks++;
    if (!ok) $display("FAIL %s_timeout: still busy after %0d cycles", tag, budget);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rr_m = 0;
    checks += 6;
    if (req_ready !== '0) $display("FAIL rst_ready: got %0h want 0", req_ready); else passes++;
    if (uart_start_tx !== 1'b0) $display("FAIL rst_start: got %0b want 0", uart_start_tx); else passes++;
    if (uart_data !== 8'h00) $display("FAIL rst_data: got %0h want 0", uart_data); else passes++;
    if (grant_id !== 3'd0) $display("FAIL rst_grant: got %0d want 0", grant_id); else passes++;
    if (active !== 1'b0) $display("FAIL rst_active: got %0b want 0", active); else passes++;
    if (wdog_err !== 1'b0) $display("FAIL rst_wdog: got %0b want 0", wdog_err); else passes++;
  endtask

  task automatic test_simultaneous();
    for (int round = 0; round < 2; round++) begin
      clear_logs();
      if (round == 0) begin
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i));
      end else begin
        push(0, 8'($urandom));
        push(3, 8'($urandom));
      end
      model_run();
      wait_idle(300, "simul");
      checks++;
      if (st_log.size() != exp_i.size())
        $display("FAIL simul_count: got %0d want %0d", st_log.size(), exp_i.size());
      else passes++;
      for (int k = 0; k < st_log.size() && k < exp_i.size(); k++) begin
        checks += 3;
        if (st_log[k].gid != exp_i[k])
          $display("FAIL simul_grant[%0d]: got %0d want %0d", k, st_log[k].gid, exp_i[k]);
        else passes++;
        if (st_log[k].data !== exp_d[k])
          $display("FAIL simul_data[%0d]: got %0h want %0h", k, st_log[k].data, exp_d[k]);
        else passes++;
        if (k >= acc_log.size() || st_log[k].cyc - acc_log[k].cyc != 1)
          $display("FAIL simul_latency[%0d]: strobe not 1 clock after accept", k);
        else passes++;
      end
    end
  endtask

  task automatic test_single();
    clear_logs();
    push(2, 8'hA5);
    model_run();
    wait_idle(100, "single");
    repeat (3) @(negedge clk);
    checks += 6;
    if (acc_log.size() != 1 || acc_log[0].idx != 2)
      $display("FAIL single_accept: got %0d accepts want 1 on req 2", acc_log.size());
    else passes++;
    if (st_log.size() != 1 || acc_log.size() != 1 || st_log[0].cyc - acc_log[0].cyc != 1)
      $display("FAIL single_latency: got %0d strobes want 1 one clock after accept", st_log.size());
    else passes++;
    if (st_log.size() < 1 || st_log[0].data !== 8'hA5)
      $display("FAIL single_data: got %0h want a5", st_log.size() ? st_log[0].data : 8'hxx);
    else passes++;
    if (st_log.size() < 1 || st_log[0].gid != 2)
      $display("FAIL single_grant: got %0d want 2", st_log.size() ? st_log[0].gid : -1);
    else passes++;
    if (fall_log.size() < 1 || done_log.size() < 1 || fall_log[0] - done_log[0] != GAP + 1)
      $display("FAIL single_active_drop: got %0d want %0d",
               (fall_log.size() && done_log.size()) ? fall_log[0] - done_log[0] : -1, GAP + 1);
    else passes++;
    if (grant_id !== 3'd2) $display("FAIL single_grant_hold: got %0d want 2", grant_id);
    else passes++;
  endtask

  task automatic test_stream();
    clear_logs();
    for (int b = 0; b < 3; b++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
    end
    model_run();
    wait_idle(400, "stream");
    checks++;
    if (st_log.size() != exp_i.size())
      $display("FAIL stream_count: got %0d want %0d", st_log.size(), exp_i.size());
    else passes++;
    for (int k = 0; k < st_log.size() && k < exp_i.size(); k++) begin
      checks += 2;
      if (st_log[k].gid != exp_i[k] || st_log[k].data !== exp_d[k])
        $display("FAIL stream_frame[%0d]: got %0d/%0h want %0d/%0h",
                 k, st_log[k].gid, st_log[k].data, exp_i[k], exp_d[k]);
      else passes++;
      if (k > 0 && (k - 1 >= done_log.size() || st_log[k].cyc - done_log[k-1] < GAP + 2))
        $display("FAIL stream_spacing[%0d]: strobe earlier than %0d clocks after done", k, GAP + 2);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(0, 3)) push(i, 8'($urandom));
      model_run();
      wait_idle(800, "random");
      checks++;
      if (st_log.size() != exp_i.size())
        $display("FAIL random_count: got %0d want %0d", st_log.size(), exp_i.size());
      else passes++;
      for (int k = 0; k < st_log.size() && k < exp_i.size(); k++) begin
        checks++;
        if (st_log[k].gid != exp_i[k] || st_log[k].data !== exp_d[k])
          $display("FAIL random_frame[%0d]: got %0d/%0h want %0d/%0h",
                   k, st_log[k].gid, st_log[k].data, exp_i[k], exp_d[k]);
        else passes++;
      end
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] b;
    clear_logs();
    wdog_rise = -1;
    tx_hang = 1'b1;
    push(1, 8'($urandom));
    model_run();
    for (int n = 0; n < 1200 && wdog_rise < 0; n++) @(negedge clk);
    checks++;
    if (wdog_rise < 0 || st_log.size() < 1 || wdog_rise - st_log[0].cyc != WDOG + 1)
      $display("FAIL wdog_timing: got %0d want %0d clocks strobe-to-err",
               (wdog_rise >= 0 && st_log.size()) ? wdog_rise - st_log[0].cyc : -1, WDOG + 1);
    else passes++;
    wait_idle(50, "wdog_abort");
    tx_hang = 1'b0;
    clear_logs();
    b = 8'($urandom);
    push(2, b);
    model_run();
    wait_idle(100, "wdog_resume");
    checks += 2;
    if (st_log.size() != 1 || st_log[0].gid != 2 || st_log[0].data !== b)
      $display("FAIL wdog_resume: got %0d frames want one from req 2 byte %0h", st_log.size(), b);
    else passes++;
    if (wdog_err !== 1'b1) $display("FAIL wdog_sticky: got %0b want 1", wdog_err);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    push(3, 8'($urandom));
    model_run();
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (uart_start_tx) seen = 1;
    end
    checks++;
    if (!seen) $display("FAIL midrst_strobe: no start strobe within 30 clocks");
    else passes++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rr_m = 0;
    checks += 6;
    if (req_ready !== '0) $display("FAIL midrst_ready: got %0h want 0", req_ready); else passes++;
    if (uart_start_tx !== 1'b0) $display("FAIL midrst_start: got %0b want 0", uart_start_tx); else passes++;
    if (uart_data !== 8'h00) $display("FAIL midrst_data: got %0h want 0", uart_data); else passes++;
    if (grant_id !== 3'd0) $display("FAIL midrst_grant: got %0d want 0", grant_id); else passes++;
    if (active !== 1'b0) $display("FAIL midrst_active: got %0b want 0", active); else passes++;
    if (wdog_err !== 1'b0) $display("FAIL midrst_wdog: got %0b want 0", wdog_err); else passes++;
    clear_logs();
    push(2, 8'($urandom));
    push(0, 8'($urandom));
    model_run();
    wait_idle(200, "midrst");
    checks++;
    if (st_log.size() != 2 || st_log[0].gid != exp_i[0] || st_log[1].gid != exp_i[1]
        || st_log[0].data !== exp_d[0])
      $display("FAIL midrst_order: got %0d frames want order %0d,%0d",
               st_log.size(), exp_i[0], exp_i[1]);
    else passes++;
  endtask

`ifdef UART_ARB_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int want[$];
    int first;
    clear_logs();
    for (int b = 0; b < 3; b++) begin
      src_q[1].push_back(8'($urandom));
      src_lq[1].push_back(b == 2);
    end
    src_q[2].push_back(8'($urandom));
    src_lq[2].push_back(1'b1);
    first = (((1 - rr_m + N) % N) < ((2 - rr_m + N) % N)) ? 1 : 2;
    if (first == 1) want = '{1, 1, 1, 2};
    else want = '{2, 1, 1, 1};
    rr_m = (want[3] + 1) % N;
    wait_idle(300, "lock");
    checks++;
    if (st_log.size() != 4) $display("FAIL lock_count: got %0d want 4", st_log.size());
    else passes++;
    for (int k = 0; k < st_log.size() && k < 4; k++) begin
      checks++;
      if (st_log[k].gid != want[k])
        $display("FAIL lock_grant[%0d]: got %0d want %0d", k, st_log[k].gid, want[k]);
      else passes++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_stream();
    test_random();
`ifdef UART_ARB_PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
